// File: rtl/motor_pkg.sv
// Shared types and duty arithmetic for the multi-channel H-bridge PWM driver.
// Duty math is done on int so that intermediate sums/differences never wrap.
package motor_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        RAMP_DN = 2'd1,
        DEAD    = 2'd2,
        BRAKE   = 2'd3
    } chan_state_e;

    localparam logic DIR_FWD = 1'b1;
    localparam logic DIR_REV = 1'b0;

    // Limit a raw duty command to the PWM period (period == fully on).
    function automatic int clamp_duty(input int cmd, input int period);
        int res;
        if (cmd > period) begin
            res = period;
        end else begin
            res = cmd;
        end
        return res;
    endfunction

    // Move cur toward tgt by at most step, never overshooting.
    function automatic int ramp_toward(input int cur, input int tgt, input int step);
        int res;
        if (cur < tgt) begin
            res = ((tgt - cur) > step) ? (cur + step) : tgt;
        end else if (cur > tgt) begin
            res = ((cur - tgt) > step) ? (cur - step) : tgt;
        end else begin
            res = cur;
        end
        return res;
    endfunction

endpackage

// File: rtl/motor_pwm_chan.sv
// One H-bridge channel: run/ramp-down/dead/brake FSM, duty ramp and
// registered IN1/IN2/EN/busy outputs, all timed by the shared period tick.
module motor_pwm_chan
    import motor_pkg::*;
#(
    parameter int PERIOD       = 10,
    parameter int DUTY_W       = 8,
    parameter int RAMP_STEP    = 1,
    parameter int DEAD_PERIODS = 2,
    parameter int CNT_W        = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic [CNT_W-1:0]  cnt,
    input  logic [DUTY_W-1:0] duty_cmd,
    input  logic              dir_cmd,
    input  logic              brake_cmd,
    output logic              in1,
    output logic              in2,
    output logic              en,
    output logic              busy
);

    localparam int DEAD_W = $clog2(DEAD_PERIODS + 1);
    localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD_PERIODS);
    localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(1);

    chan_state_e       state_r;
    logic              cur_dir_r;
    logic [DUTY_W-1:0] cur_duty_r;
    logic [DUTY_W-1:0] tgt_r;
    logic [DEAD_W-1:0] dead_cnt_r;

    logic [DUTY_W-1:0] tgt_s;
    logic [DUTY_W-1:0] step_run_s;
    logic [DUTY_W-1:0] step_dn_s;
    logic [DUTY_W-1:0] step_start_s;
    logic              in1_s;
    logic              in2_s;
    logic              en_s;
    logic              busy_s;

    // Clamped target and the three possible ramp results for this tick.
    always_comb begin
        tgt_s        = DUTY_W'(clamp_duty(int'(duty_cmd), PERIOD));
        step_run_s   = DUTY_W'(ramp_toward(int'(cur_duty_r), int'(tgt_s), RAMP_STEP));
        step_dn_s    = DUTY_W'(ramp_toward(int'(cur_duty_r), 0, RAMP_STEP));
        step_start_s = DUTY_W'(ramp_toward(0, int'(tgt_s), RAMP_STEP));
    end

    // Channel FSM: brake acts every clock, everything else on the period tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= DEAD;
            dead_cnt_r <= DEAD_LOAD;
            cur_duty_r <= '0;
            cur_dir_r  <= DIR_FWD;
            tgt_r      <= '0;
        end else begin
            if (tick) begin
                tgt_r <= tgt_s;
            end else begin
                tgt_r <= tgt_r;
            end

            if (brake_cmd) begin
                state_r    <= BRAKE;
                cur_duty_r <= '0;
            end else if (state_r == BRAKE) begin
                state_r    <= DEAD;
                dead_cnt_r <= DEAD_LOAD;
            end else if (tick) begin
                case (state_r)
                    RUN: begin
                        if (dir_cmd != cur_dir_r) begin
                            if (cur_duty_r == '0) begin
                                state_r    <= DEAD;
                                dead_cnt_r <= DEAD_LOAD;
                            end else begin
                                state_r <= RAMP_DN;
                            end
                        end else begin
                            cur_duty_r <= step_run_s;
                        end
                    end
                    RAMP_DN: begin
                        // Reversal cancelled before reaching zero: resume without dead time.
                        if (dir_cmd == cur_dir_r) begin
                            state_r <= RUN;
                        end else begin
                            cur_duty_r <= step_dn_s;
                            if (step_dn_s == '0) begin
                                state_r    <= DEAD;
                                dead_cnt_r <= DEAD_LOAD;
                            end
                        end
                    end
                    DEAD: begin
                        if (dead_cnt_r <= DEAD_LAST) begin
                            state_r    <= RUN;
                            cur_dir_r  <= dir_cmd;
                            cur_duty_r <= step_start_s;
                        end else begin
                            dead_cnt_r <= dead_cnt_r - DEAD_W'(1);
                        end
                    end
                    default: begin
                        state_r    <= DEAD;
                        dead_cnt_r <= DEAD_LOAD;
                        cur_duty_r <= '0;
                    end
                endcase
            end
        end
    end

    // Next bridge drive; a brake request overrides the state immediately.
    always_comb begin
        in1_s  = 1'b0;
        in2_s  = 1'b0;
        en_s   = 1'b0;
        busy_s = 1'b1;
        if (brake_cmd) begin
            in1_s  = 1'b1;
            in2_s  = 1'b1;
            en_s   = 1'b1;
            busy_s = 1'b0;
        end else begin
            case (state_r)
                RUN, RAMP_DN: begin
                    in1_s = cur_dir_r;
                    in2_s = ~cur_dir_r;
                    en_s  = (DUTY_W'(cnt) < cur_duty_r);
                end
                default: begin
                    in1_s = 1'b0;
                    in2_s = 1'b0;
                    en_s  = 1'b0;
                end
            endcase
            busy_s = (state_r != RUN) || (cur_duty_r != tgt_r);
        end
    end

    // Output registers; reset forces the bridge off at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in1  <= 1'b0;
            in2  <= 1'b0;
            en   <= 1'b0;
            busy <= 1'b1;
        end else begin
            in1  <= in1_s;
            in2  <= in2_s;
            en   <= en_s;
            busy <= busy_s;
        end
    end

endmodule

// File: rtl/motor_pwm_ctrl.sv
// Multi-channel H-bridge motor driver: one shared PWM period counter feeding
// N_CH independent channel controllers.
module motor_pwm_ctrl
    import motor_pkg::*;
#(
    parameter int N_CH         = 2,
    parameter int PERIOD       = 10,
    parameter int DUTY_W       = 8,
    parameter int RAMP_STEP    = 1,
    parameter int DEAD_PERIODS = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH*DUTY_W-1:0]   duty_cmd,
    input  logic [N_CH-1:0]          dir_cmd,
    input  logic [N_CH-1:0]          brake_cmd,
    output logic [N_CH-1:0]          in1,
    output logic [N_CH-1:0]          in2,
    output logic [N_CH-1:0]          en,
    output logic [N_CH-1:0]          busy
);

    localparam int CNT_W = $clog2(PERIOD);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] cnt_r;
    logic             tick_s;

    assign tick_s = (cnt_r == CNT_LAST);

    // Shared PWM period counter, 0..PERIOD-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (tick_s) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        motor_pwm_chan #(
            .PERIOD       (PERIOD),
            .DUTY_W       (DUTY_W),
            .RAMP_STEP    (RAMP_STEP),
            .DEAD_PERIODS (DEAD_PERIODS),
            .CNT_W        (CNT_W)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .tick      (tick_s),
            .cnt       (cnt_r),
            .duty_cmd  (duty_cmd[i*DUTY_W +: DUTY_W]),
            .dir_cmd   (dir_cmd[i]),
            .brake_cmd (brake_cmd[i]),
            .in1       (in1[i]),
            .in2       (in2[i]),
            .en        (en[i]),
            .busy      (busy[i])
        );
    end

endmodule

// File: tb/tb_motor_pwm_ctrl.sv
// Directed bench for motor_pwm_ctrl: per-period on-time and bridge levels
// against hand-computed values for ramp, reversal, clamp, brake and reset.
`timescale 1ns/1ps
module tb_motor_pwm_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] duty_cmd;
    logic [1:0]  dir_cmd;
    logic [1:0]  brake_cmd;
    logic [1:0]  in1;
    logic [1:0]  in2;
    logic [1:0]  en;
    logic [1:0]  busy;

    int n_checks = 0;
    int n_errors = 0;
    int on0;
    int on1;
    logic smp_en0   [10];
    logic smp_in1_0 [10];
    logic smp_in2_0 [10];
    logic smp_busy0 [10];
    int exp_rev [14] = '{5, 5, 4, 3, 2, 1, 0, 0, 1, 2, 3, 4, 5, 5};

    motor_pwm_ctrl #(
        .N_CH         (2),
        .PERIOD       (10),
        .DUTY_W       (8),
        .RAMP_STEP    (1),
        .DEAD_PERIODS (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .duty_cmd  (duty_cmd),
        .dir_cmd   (dir_cmd),
        .brake_cmd (brake_cmd),
        .in1       (in1),
        .in2       (in2),
        .en        (en),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Ten negedge samples = one PWM period of registered outputs; optional input change at act_idx.
    task automatic sample_window(input int act_idx, input logic [15:0] a_duty,
                                 input logic [1:0] a_dir, input logic [1:0] a_brake,
                                 output int o0, output int o1);
        o0 = 0;
        o1 = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == act_idx) begin
                duty_cmd  = a_duty;
                dir_cmd   = a_dir;
                brake_cmd = a_brake;
            end
            smp_en0[i]   = en[0];
            smp_in1_0[i] = in1[0];
            smp_in2_0[i] = in2[0];
            smp_busy0[i] = busy[0];
            o0 += int'(en[0]);
            o1 += int'(en[1]);
            @(negedge clk);
        end
    endtask

    task automatic win();
        sample_window(-1, duty_cmd, dir_cmd, brake_cmd, on0, on1);
    endtask

    initial begin
        rst       = 1'b1;
        duty_cmd  = {8'd7, 8'd10};
        dir_cmd   = 2'b11;
        brake_cmd = 2'b00;
        repeat (3) @(negedge clk);
        check_val("rst_en", en, 32'd0);
        check_val("rst_in1", in1, 32'd0);
        check_val("rst_in2", in2, 32'd0);
        check_val("rst_busy", busy, 32'd3);
        rst = 1'b0;
        @(negedge clk);

        // Ramp-up after reset: two dead periods, then 1..10.
        for (int w = 0; w < 12; w++) begin
            win();
            check_val($sformatf("t1_on0_w%0d", w), on0, (w < 2) ? 0 : (w - 1));
            if (w == 1) begin
                check_val("t1_in1_dead", smp_in1_0[9], 32'd0);
                check_val("t1_in2_dead", smp_in2_0[9], 32'd0);
            end
            if (w == 2) begin
                check_val("t1_in1_run", smp_in1_0[9], 32'd1);
                check_val("t1_in2_run", smp_in2_0[9], 32'd0);
            end
            if (w == 8) check_val("t1_on1_w8", on1, 32'd7);
            if (w == 10) check_val("t1_busy_w10", smp_busy0[9], 32'd1);
            if (w == 11) check_val("t1_busy_w11", smp_busy0[9], 32'd0);
        end

        // Clamp of an oversize command, then a mid-period change.
        duty_cmd[7:0] = 8'd200;
        win();
        check_val("t3_on0_w12", on0, 32'd10);
        win();
        check_val("t3_on0_w13", on0, 32'd10);
        check_val("t3_busy_w13", smp_busy0[9], 32'd0);
        sample_window(2, {8'd7, 8'd5}, dir_cmd, brake_cmd, on0, on1);
        check_val("t3_on0_midchg", on0, 32'd10);
        for (int k = 0; k < 6; k++) begin
            win();
            check_val($sformatf("t3_on0_dn%0d", k), on0, (k < 5) ? (9 - k) : 5);
            if (k == 4) check_val("t3_busy_settled", smp_busy0[9], 32'd0);
        end

        // Reversal of ch0 while ch1 runs steady at 7.
        dir_cmd[0] = 1'b0;
        for (int k = 0; k < 14; k++) begin
            win();
            check_val($sformatf("t2_on0_k%0d", k), on0, exp_rev[k]);
            check_val($sformatf("t5_on1_k%0d", k), on1, 32'd7);
            if (k == 1) begin
                check_val("t2_in1_rampdn", smp_in1_0[9], 32'd1);
                check_val("t2_in2_rampdn", smp_in2_0[9], 32'd0);
            end
            if (k == 6) begin
                check_val("t2_in1_dead", smp_in1_0[9], 32'd0);
                check_val("t2_in2_dead", smp_in2_0[9], 32'd0);
            end
            if (k == 8) begin
                check_val("t2_in1_rev", smp_in1_0[9], 32'd0);
                check_val("t2_in2_rev", smp_in2_0[9], 32'd1);
            end
            if (k == 13) check_val("t2_busy_settled", smp_busy0[9], 32'd0);
        end

        // Brake mid-period while running, then release.
        sample_window(4, duty_cmd, dir_cmd, 2'b01, on0, on1);
        check_val("t4_en_next", smp_en0[5], 32'd1);
        check_val("t4_in1_next", smp_in1_0[5], 32'd1);
        check_val("t4_in2_next", smp_in2_0[5], 32'd1);
        check_val("t4_busy_brake", smp_busy0[5], 32'd0);
        check_val("t4_on0_w35", on0, 32'd10);
        win();
        check_val("t4_on0_held", on0, 32'd10);
        sample_window(0, duty_cmd, dir_cmd, 2'b00, on0, on1);
        check_val("t4_on0_release", on0, 32'd1);
        check_val("t4_busy_release", smp_busy0[1], 32'd1);
        check_val("t4_in1_release", smp_in1_0[9], 32'd0);
        win();
        check_val("t4_on0_dead", on0, 32'd0);
        win();
        check_val("t4_on0_ramp1", on0, 32'd1);
        check_val("t4_in2_ramp1", smp_in2_0[9], 32'd1);
        win();
        check_val("t4_on0_ramp2", on0, 32'd2);

        // Brake and direction change on the tick edge: brake wins.
        sample_window(8, duty_cmd, 2'b11, 2'b01, on0, on1);
        check_val("t5_on0_w41", on0, 32'd4);
        check_val("t5_en_brk", smp_en0[9], 32'd1);
        check_val("t5_in1_brk", smp_in1_0[9], 32'd1);
        check_val("t5_in2_brk", smp_in2_0[9], 32'd1);
        win();
        check_val("t5_on0_held", on0, 32'd10);
        check_val("t5_busy_held", smp_busy0[9], 32'd0);
        check_val("t5_on1_held", on1, 32'd7);
        sample_window(0, duty_cmd, dir_cmd, 2'b00, on0, on1);
        check_val("t5_on0_release", on0, 32'd1);
        win();
        check_val("t5_on0_dead", on0, 32'd0);
        win();
        check_val("t5_on0_fwd1", on0, 32'd1);
        check_val("t5_in1_fwd", smp_in1_0[9], 32'd1);
        check_val("t5_in2_fwd", smp_in2_0[9], 32'd0);

        // Asynchronous reset pulse during ramp-down.
        for (int k = 0; k < 4; k++) begin
            win();
            check_val($sformatf("t6_on0_up%0d", k), on0, k + 2);
        end
        dir_cmd[0] = 1'b0;
        win();
        check_val("t6_on0_w50", on0, 32'd5);
        win();
        check_val("t6_on0_w51", on0, 32'd5);
        check_val("t6_in1_rampdn", smp_in1_0[9], 32'd1);
        #2 rst = 1'b1;
        #1;
        check_val("t6_en_async", en, 32'd0);
        check_val("t6_in1_async", in1, 32'd0);
        check_val("t6_in2_async", in2, 32'd0);
        check_val("t6_busy_async", busy, 32'd3);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int w = 0; w < 3; w++) begin
            win();
            check_val($sformatf("t6_on0_w%0d", w), on0, (w < 2) ? 0 : 1);
            if (w == 1) check_val("t6_in1_dead", smp_in1_0[9], 32'd0);
            if (w == 2) begin
                check_val("t6_in1_rev", smp_in1_0[9], 32'd0);
                check_val("t6_in2_rev", smp_in2_0[9], 32'd1);
                check_val("t6_on1_w2", on1, 32'd1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
